// File: rtl/radar_echo_pkg.sv
// Shared types and helpers for the radar echo responder: FSM encoding, default timing
// constants and the saturating range update used by the moving-target model.
package radar_echo_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COMPUTE,
    ST_WAIT_FALL,
    ST_DELAY,
    ST_ECHO
  } state_e;

  localparam int unsigned MM_PER_DELAY_DFLT = 150000;
  localparam int unsigned MAX_DELAY_DFLT    = 2000;

  // range - speed, with speed as two's complement, clamped to [0, 32'hFFFF_FFFF].
  function automatic logic [31:0] sat_sub32(input logic [31:0] range,
                                            input logic [31:0] speed);
    logic [33:0] diff;
    diff = {2'b00, range} - {{2{speed[31]}}, speed};
    if (diff[33])      return 32'h0000_0000;
    else if (diff[32]) return 32'hFFFF_FFFF;
    else               return diff[31:0];
  endfunction

endpackage

// File: rtl/range_delay_div.sv
// 32-bit unsigned restoring divider, one quotient bit per cycle.
// done_o pulses 33 cycles after start_i; abort_i cancels an operation in flight.
module range_delay_div (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic        done_o,
  output logic [31:0] quotient_o
);

  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [4:0]  step_q, step_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] div_q, div_d;
  logic [32:0] rem_shift, rem_trial;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves it unassigned (no latch).
    busy_d    = busy_q;
    done_d    = 1'b0;
    step_d    = step_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    div_d     = div_q;
    rem_shift = {rem_q, quo_q[31]};
    rem_trial = rem_shift - {1'b0, div_q};

    if (abort_i) begin
      busy_d = 1'b0;
    end else if (start_i) begin
      busy_d = 1'b1;
      step_d = '0;
      rem_d  = '0;
      quo_d  = dividend_i;
      div_d  = divisor_i;
    end else if (busy_q) begin
      // Remainder stays below the divisor, so bit 32 of the trial acts as the borrow.
      if (!rem_trial[32]) begin
        rem_d = rem_trial[31:0];
        quo_d = {quo_q[30:0], 1'b1};
      end else begin
        rem_d = rem_shift[31:0];
        quo_d = {quo_q[30:0], 1'b0};
      end
      step_d = step_q + 5'd1;
      if (step_q == 5'd31) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      step_q <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      div_q  <= '0;
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values, independent of order.
      busy_q <= busy_d;
      done_q <= done_d;
      step_q <= step_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      div_q  <= div_d;
    end
  end

  assign done_o     = done_q;
  assign quotient_o = quo_q;

endmodule

// File: rtl/radar_echo_responder.sv
// Target-side responder: models a moving target's range and answers each radar trigger
// with an echo pulse delayed by the round-trip time of the range snapshot taken at the rise.
module radar_echo_responder
  import radar_echo_pkg::*;
#(
  parameter int unsigned CYC_PER_MS   = 1000,
  parameter int unsigned MM_PER_DELAY = MM_PER_DELAY_DFLT,
  parameter int unsigned ECHO_WIDTH   = 10,
  parameter int unsigned MAX_DELAY    = MAX_DELAY_DFLT,
  parameter int unsigned MIN_PULSE    = 34
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        target_load,
  input  logic [31:0] target_init_range_mm,
  input  logic [31:0] closing_speed_mps,
  input  logic        radar_pulse_trigger,
  output logic        radar_echo,
  output logic [31:0] target_range_mm,
  output logic [31:0] echo_delay_us,
  output logic        echo_busy,
  output logic        no_echo,
  output logic        pulse_dropped
);

  localparam int PW = $clog2(CYC_PER_MS);
  localparam int HW = $clog2(MIN_PULSE + 1);

  state_e          state_q, state_d;
  logic            trig_q;
  logic [PW-1:0]   pre_q, pre_d;
  logic [31:0]     range_q, range_d;
  logic [HW-1:0]   hi_q, hi_d;
  logic [31:0]     cnt_q, cnt_d;
  logic [31:0]     delay_q, delay_d;
  logic            no_echo_q, no_echo_d;
  logic            drop_q, drop_d;
  logic            rise, fall, wrap;
  logic            div_start, div_abort, div_done;
  logic [31:0]     div_quot;

  assign rise = radar_pulse_trigger & ~trig_q;
  assign fall = ~radar_pulse_trigger & trig_q;
  assign wrap = (pre_q == PW'(CYC_PER_MS - 1));

  // One prescaler wrap per millisecond: m/s over 1 ms is exactly mm.
  always_comb begin
    pre_d   = wrap ? '0 : pre_q + PW'(1);
    range_d = range_q;
    if (target_load)  range_d = target_init_range_mm;
    else if (wrap)    range_d = sat_sub32(range_q, closing_speed_mps);
    hi_d = hi_q;
    if (rise)                                          hi_d = HW'(1);
    else if (radar_pulse_trigger && hi_q < HW'(MIN_PULSE)) hi_d = hi_q + HW'(1);
  end

  range_delay_div u_div (
    .CLK        (CLK),
    .RST        (RST),
    .start_i    (div_start),
    .abort_i    (div_abort),
    .dividend_i (range_q),
    .divisor_i  (32'(MM_PER_DELAY)),
    .done_o     (div_done),
    .quotient_o (div_quot)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    delay_d   = delay_q;
    no_echo_d = 1'b0;
    drop_d    = 1'b0;
    div_start = 1'b0;
    div_abort = 1'b0;

    if (rise && state_q != ST_IDLE) drop_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          div_start = 1'b1;
          state_d   = ST_COMPUTE;
        end
      end
      ST_COMPUTE: begin
        if (fall) begin
          drop_d    = 1'b1;
          div_abort = 1'b1;
          state_d   = ST_IDLE;
        end else if (div_done) begin
          delay_d = div_quot;
          state_d = ST_WAIT_FALL;
        end
      end
      ST_WAIT_FALL: begin
        if (fall) begin
          if (hi_q < HW'(MIN_PULSE)) begin
            drop_d  = 1'b1;
            state_d = ST_IDLE;
          end else if (delay_q > 32'(MAX_DELAY)) begin
            no_echo_d = 1'b1;
            state_d   = ST_IDLE;
          end else if (delay_q == '0) begin
            cnt_d   = 32'(ECHO_WIDTH - 1);
            state_d = ST_ECHO;
          end else begin
            // Counter reaches zero in cycle F+delay, so the echo starts in F+1+delay.
            cnt_d   = delay_q - 32'd1;
            state_d = ST_DELAY;
          end
        end
      end
      ST_DELAY: begin
        if (cnt_q == '0) begin
          cnt_d   = 32'(ECHO_WIDTH - 1);
          state_d = ST_ECHO;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      ST_ECHO: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 32'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      trig_q    <= 1'b0;
      pre_q     <= '0;
      range_q   <= '0;
      hi_q      <= '0;
      cnt_q     <= '0;
      delay_q   <= '0;
      no_echo_q <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      trig_q    <= radar_pulse_trigger;
      pre_q     <= pre_d;
      range_q   <= range_d;
      hi_q      <= hi_d;
      cnt_q     <= cnt_d;
      delay_q   <= delay_d;
      no_echo_q <= no_echo_d;
      drop_q    <= drop_d;
    end
  end

  assign radar_echo      = (state_q == ST_ECHO);
  assign echo_busy       = (state_q != ST_IDLE);
  assign target_range_mm = range_q;
  assign echo_delay_us   = delay_q;
  assign no_echo         = no_echo_q;
  assign pulse_dropped   = drop_q;

endmodule

// File: tb/tb_radar_echo_responder.sv
// Directed self-checking bench for radar_echo_responder: echo timing, silence beyond the
// listen window, range model with saturation, dropped pulses and asynchronous reset.
module tb_radar_echo_responder;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        target_load = 1'b0;
  logic [31:0] target_init_range_mm = '0;
  logic [31:0] closing_speed_mps = '0;
  logic        radar_pulse_trigger = 1'b0;
  logic        radar_echo;
  logic [31:0] target_range_mm;
  logic [31:0] echo_delay_us;
  logic        echo_busy;
  logic        no_echo;
  logic        pulse_dropped;

  int n_cmp = 0;
  int n_mis = 0;

  radar_echo_responder dut (
    .CLK                  (CLK),
    .RST                  (RST),
    .target_load          (target_load),
    .target_init_range_mm (target_init_range_mm),
    .closing_speed_mps    (closing_speed_mps),
    .radar_pulse_trigger  (radar_pulse_trigger),
    .radar_echo           (radar_echo),
    .target_range_mm      (target_range_mm),
    .echo_delay_us        (echo_delay_us),
    .echo_busy            (echo_busy),
    .no_echo              (no_echo),
    .pulse_dropped        (pulse_dropped)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, got, got, exp, exp);
    end
  endtask

  // Advance n rising edges; inputs change and outputs are sampled 1 ns after each edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic load_range(input logic [31:0] mm);
    target_init_range_mm = mm;
    target_load = 1'b1;
    tick(1);
    target_load = 1'b0;
  endtask

  // Returns in the cycle where the falling trigger is sampled (cycle F).
  task automatic pulse(input int len);
    radar_pulse_trigger = 1'b1;
    tick(len);
    radar_pulse_trigger = 1'b0;
  endtask

  task automatic count_echo(input int cycles, output int highs);
    highs = 0;
    for (int i = 0; i < cycles; i++) begin
      tick(1);
      if (radar_echo) highs++;
    end
  endtask

  int highs;

  initial begin
    tick(3);
    check("reset echo", 32'(radar_echo), 0);
    check("reset busy", 32'(echo_busy), 0);
    check("reset range", target_range_mm, 0);
    check("reset delay", echo_delay_us, 0);
    check("reset no_echo", 32'(no_echo), 0);
    check("reset dropped", 32'(pulse_dropped), 0);
    RST = 1'b0;
    tick(2);

    // 15 km -> 100 us delay, echo high F+101..F+110
    closing_speed_mps = 0;
    load_range(32'd15_000_000);
    pulse(300);
    check("A busy at fall", 32'(echo_busy), 1);
    tick(100);
    check("A delay", echo_delay_us, 100);
    check("A echo before F+101", 32'(radar_echo), 0);
    tick(1);
    check("A echo at F+101", 32'(radar_echo), 1);
    tick(9);
    check("A echo at F+110", 32'(radar_echo), 1);
    tick(1);
    check("A echo at F+111", 32'(radar_echo), 0);
    check("A busy after echo", 32'(echo_busy), 0);

    // 400 km -> 2666 us, beyond the listen window
    load_range(32'd400_000_000);
    pulse(300);
    tick(1);
    check("B no_echo strobe", 32'(no_echo), 1);
    check("B delay", echo_delay_us, 2666);
    check("B busy", 32'(echo_busy), 0);
    tick(1);
    check("B no_echo cleared", 32'(no_echo), 0);
    count_echo(2100, highs);
    check("B echo silent", 32'(highs), 0);

    // Range model: 300 m/s closing for 10 ms, then receding
    closing_speed_mps = 32'd300;
    load_range(32'd15_000_000);
    tick(5000);
    check("C range 5ms", target_range_mm, 32'd14_998_500);
    tick(5000);
    check("C range 10ms", target_range_mm, 32'd14_997_000);
    closing_speed_mps = -32'sd300;
    tick(10000);
    check("C range receding", target_range_mm, 32'd15_000_000);

    // Saturation at both ends
    closing_speed_mps = 32'd5000;
    load_range(32'd1000);
    tick(1000);
    check("D sat low", target_range_mm, 0);
    tick(1000);
    check("D sat low hold", target_range_mm, 0);
    closing_speed_mps = -32'sd1000;
    load_range(32'hFFFF_FF00);
    tick(1000);
    check("D sat high", target_range_mm, 32'hFFFF_FFFF);
    tick(1000);
    check("D sat high hold", target_range_mm, 32'hFFFF_FFFF);

    // Zero range: echo the cycle after the fall
    closing_speed_mps = 0;
    load_range(32'd0);
    pulse(300);
    tick(1);
    check("E echo at F+1", 32'(radar_echo), 1);
    check("E delay", echo_delay_us, 0);
    tick(9);
    check("E echo at F+10", 32'(radar_echo), 1);
    tick(1);
    check("E echo at F+11", 32'(radar_echo), 0);

    // Minimum pulse boundary: 33 dropped, 34 answered
    pulse(33);
    tick(1);
    check("M 33 dropped", 32'(pulse_dropped), 1);
    check("M 33 no echo", 32'(radar_echo), 0);
    pulse(34);
    tick(1);
    check("M 34 echo", 32'(radar_echo), 1);
    check("M 34 not dropped", 32'(pulse_dropped), 0);
    tick(10);
    check("M 34 echo end", 32'(radar_echo), 0);

    // Rise during ECHO's last cycle is dropped
    pulse(300);
    tick(10);
    radar_pulse_trigger = 1'b1;
    tick(1);
    check("H last-cycle rise dropped", 32'(pulse_dropped), 1);
    check("H idle after echo", 32'(echo_busy), 0);
    tick(5);
    radar_pulse_trigger = 1'b0;
    count_echo(50, highs);
    check("H no second echo", 32'(highs), 0);

    // Short 20-cycle trigger
    load_range(32'd15_000_000);
    pulse(20);
    tick(1);
    check("F short dropped", 32'(pulse_dropped), 1);
    check("F short idle", 32'(echo_busy), 0);
    tick(1);
    check("F dropped cleared", 32'(pulse_dropped), 0);
    count_echo(200, highs);
    check("F no echo", 32'(highs), 0);

    // Second rise during DELAY leaves the first echo intact
    pulse(300);
    tick(20);
    radar_pulse_trigger = 1'b1;
    tick(1);
    check("G rise in DELAY dropped", 32'(pulse_dropped), 1);
    check("G still busy", 32'(echo_busy), 1);
    tick(4);
    radar_pulse_trigger = 1'b0;
    tick(75);
    check("G echo before F+101", 32'(radar_echo), 0);
    tick(1);
    check("G echo at F+101", 32'(radar_echo), 1);
    tick(9);
    check("G echo at F+110", 32'(radar_echo), 1);
    tick(1);
    check("G echo at F+111", 32'(radar_echo), 0);

    // Asynchronous reset in the middle of an echo
    pulse(300);
    tick(104);
    check("I echo before reset", 32'(radar_echo), 1);
    #2 RST = 1'b1;
    #1;
    check("I echo async drop", 32'(radar_echo), 0);
    check("I busy async drop", 32'(echo_busy), 0);
    check("I range reset", target_range_mm, 0);
    tick(2);
    RST = 1'b0;
    tick(1);
    load_range(32'd15_000_000);
    pulse(300);
    tick(100);
    check("I re-echo before F+101", 32'(radar_echo), 0);
    check("I re-delay", echo_delay_us, 100);
    tick(1);
    check("I re-echo at F+101", 32'(radar_echo), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
